pes_gcmonitor: RTL and testbench

Downstream consumer of the 8-bit Gray-code counter `pes_gccounter`. It samples the counter's `gray_count` and `enable` and produces registered outputs:

- the binary equivalent of the count,
- a wrap pulse,
- a lock indication,
- single-cycle step and stall error pulses,
- a saturating error count.

It sits between the counter and any logic that needs binary counts or a sequence-integrity check.

---
 rtl/pes_gcmonitor.sv | 135 +++++++++++++
 tb/tb_pes_gcmonitor.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pes_gcmonitor.sv
// Sequence monitor for an 8-bit Gray-code counter: converts the sampled code to binary,
// classifies each step (hold/advance/bad), tracks lock, and flags step/stall errors.
module pes_gcmonitor #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 2,
  parameter int STALL_MAX  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             locked,
  output logic             wrap_pulse,
  output logic             step_err,
  output logic             stall_err,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_e;

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [WIDTH-1:0] gray_q, bin_q, bin_new, diff;
  logic             en_q, s1v_q, bvld_q;
  state_e           state_q, state_d;
  logic [3:0]       lock_cnt_q, lock_cnt_d;
  logic [7:0]       stall_cnt_q, stall_cnt_d;
  logic [7:0]       err_q, err_d;
  logic             wrap_q, wrap_d, step_q, step_d, stall_q, stall_d, locked_q;
  logic             classify, is_hold, is_adv, is_bad, stall_inc, stall_hit;

  assign bin_new   = g2b(gray_q);
  assign diff      = bin_new - bin_q;
  assign classify  = bvld_q && s1v_q;
  assign is_hold   = (diff == '0);
  assign is_adv    = (diff == WIDTH'(1));
  assign is_bad    = !is_hold && !is_adv;
  assign stall_inc = classify && is_hold && en_q;
  assign stall_hit = stall_inc && (stall_cnt_q == 8'(STALL_MAX-1));

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    stall_cnt_d = stall_cnt_q;
    step_d      = 1'b0;
    stall_d     = 1'b0;
    wrap_d      = classify && is_adv && (bin_q == '1);
    if (classify) begin
      // Stall count restarts on any non-stalling sample and after each stall event
      stall_cnt_d = (stall_inc && !stall_hit) ? stall_cnt_q + 8'd1 : 8'd0;
      case (state_q)
        UNLOCKED: begin
          state_d    = CHECK;
          lock_cnt_d = '0;
        end
        CHECK: begin
          if (is_adv) begin
            if (lock_cnt_q == 4'(LOCK_COUNT-1)) begin
              state_d    = LOCKED;
              lock_cnt_d = '0;
            end else begin
              lock_cnt_d = lock_cnt_q + 4'd1;
            end
          end else if (is_bad) begin
            lock_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (is_bad) begin
            step_d     = 1'b1;
            state_d    = CHECK;
            lock_cnt_d = '0;
          end else if (stall_hit) begin
            stall_d    = 1'b1;
            state_d    = CHECK;
            lock_cnt_d = '0;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
    err_d = err_q;
    if ((step_d || stall_d) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gray_q      <= '0;
      en_q        <= 1'b0;
      s1v_q       <= 1'b0;
      bin_q       <= '0;
      bvld_q      <= 1'b0;
      state_q     <= UNLOCKED;
      lock_cnt_q  <= '0;
      stall_cnt_q <= '0;
      err_q       <= '0;
      wrap_q      <= 1'b0;
      step_q      <= 1'b0;
      stall_q     <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      gray_q      <= gray_in;
      en_q        <= enable;
      s1v_q       <= 1'b1;
      if (s1v_q) begin
        bin_q  <= bin_new;
        bvld_q <= 1'b1;
      end
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
      wrap_q      <= wrap_d;
      step_q      <= step_d;
      stall_q     <= stall_d;
      locked_q    <= (state_d == LOCKED);
    end
  end

  assign bin_out    = bin_q;
  assign bin_valid  = bvld_q;
  assign locked     = locked_q;
  assign wrap_pulse = wrap_q;
  assign step_err   = step_q;
  assign stall_err  = stall_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_pes_gcmonitor.sv
// Directed bench for pes_gcmonitor: reset, free-run with wrap, illegal step, stall,
// error-count saturation and reset while locked.
module tb_pes_gcmonitor;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] gray_in = 8'h00;
  logic [7:0] bin_out, err_count;
  logic       bin_valid, locked, wrap_pulse, step_err, stall_err;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] v;

  always #5 clk = ~clk;

  pes_gcmonitor #(.WIDTH(8), .LOCK_COUNT(2), .STALL_MAX(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .gray_in(gray_in),
    .bin_out(bin_out), .bin_valid(bin_valid), .locked(locked),
    .wrap_pulse(wrap_pulse), .step_err(step_err), .stall_err(stall_err),
    .err_count(err_count)
  );

  function automatic logic [7:0] g(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".bin_out"}, 32'(bin_out), 0);
    chk({tag, ".bin_valid"}, 32'(bin_valid), 0);
    chk({tag, ".locked"}, 32'(locked), 0);
    chk({tag, ".wrap"}, 32'(wrap_pulse), 0);
    chk({tag, ".step_err"}, 32'(step_err), 0);
    chk({tag, ".stall_err"}, 32'(stall_err), 0);
    chk({tag, ".err_count"}, 32'(err_count), 0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one counter value; it is sampled at the edge this task waits for
  task automatic feed(input logic [7:0] b, input logic en);
    gray_in = g(b);
    enable  = en;
    tick();
  endtask

  initial begin
    // Power-on reset with the counter held at 0
    enable  = 1'b1;
    gray_in = g(8'd0);
    #3;
    chk_zero("por");
    tick();
    tick();
    chk_zero("por_held");
    reset = 1'b1;

    // Free-run: counter advances on every edge after release
    for (int n = 1; n <= 300; n++) begin
      tick();
      chk("run.bin_valid", 32'(bin_valid), 32'(n >= 2));
      chk("run.bin_out", 32'(bin_out), (n >= 2) ? 32'((n - 2) % 256) : 0);
      chk("run.locked", 32'(locked), 32'(n >= 5));
      chk("run.wrap", 32'(wrap_pulse), 32'(n == 258));
      chk("run.err_count", 32'(err_count), 0);
      chk("run.step_err", 32'(step_err), 0);
      chk("run.stall_err", 32'(stall_err), 0);
      gray_in = g(8'(n));
    end

    // Short reset pulse while locked
    chk("midlock.pre_locked", 32'(locked), 1);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    chk_zero("midlock");

    // Restart, lock across the wrap, then jump bin 2 -> 4
    feed(8'd253, 1'b1); chk("ill.e1.valid", 32'(bin_valid), 0);
    feed(8'd254, 1'b1); chk("ill.e2.valid", 32'(bin_valid), 1);
                        chk("ill.e2.bin", 32'(bin_out), 253);
    feed(8'd255, 1'b1); chk("ill.e3.bin", 32'(bin_out), 254);
                        chk("ill.e3.locked", 32'(locked), 0);
    feed(8'd0, 1'b1);   chk("ill.e4.locked", 32'(locked), 0);
                        chk("ill.e4.wrap", 32'(wrap_pulse), 0);
    feed(8'd1, 1'b1);   chk("ill.e5.bin", 32'(bin_out), 0);
                        chk("ill.e5.locked", 32'(locked), 1);
                        chk("ill.e5.wrap", 32'(wrap_pulse), 1);
    feed(8'd2, 1'b1);   chk("ill.e6.wrap", 32'(wrap_pulse), 0);
    feed(8'd4, 1'b1);   chk("ill.e7.bin", 32'(bin_out), 2);
                        chk("ill.e7.step", 32'(step_err), 0);
    feed(8'd5, 1'b1);   chk("ill.e8.bin", 32'(bin_out), 4);
                        chk("ill.e8.step", 32'(step_err), 1);
                        chk("ill.e8.locked", 32'(locked), 0);
                        chk("ill.e8.err", 32'(err_count), 1);
    feed(8'd6, 1'b1);   chk("ill.e9.step", 32'(step_err), 0);
                        chk("ill.e9.locked", 32'(locked), 0);
                        chk("ill.e9.err", 32'(err_count), 1);
    feed(8'd7, 1'b1);   chk("ill.e10.locked", 32'(locked), 1);

    // Hold with enable=1: fourth hold sample raises stall_err
    for (int i = 1; i <= 5; i++) begin
      feed(8'd7, 1'b1);
      chk("stall.pulse", 32'(stall_err), 32'(i == 5));
      chk("stall.locked", 32'(locked), 32'(i != 5));
    end
    chk("stall.err", 32'(err_count), 2);
    feed(8'd7, 1'b1);  chk("stall.after", 32'(stall_err), 0);
                       chk("stall.after_locked", 32'(locked), 0);
    feed(8'd8, 1'b1);
    feed(8'd9, 1'b1);
    feed(8'd10, 1'b1); chk("stall.relock", 32'(locked), 1);

    // Same hold with enable=0 must not stall
    for (int i = 1; i <= 6; i++) begin
      feed(8'd10, 1'b0);
      chk("hold_en0.stall", 32'(stall_err), 0);
      chk("hold_en0.locked", 32'(locked), 1);
      chk("hold_en0.err", 32'(err_count), 2);
    end

    // Alternate illegal step and relock; count must stop at 255
    v = 8'd10;
    for (int it = 1; it <= 260; it++) begin
      feed(v + 8'd2, 1'b1);
      feed(v + 8'd3, 1'b1);
      feed(v + 8'd4, 1'b1);
      v = v + 8'd4;
      chk("sat.err", 32'(err_count), (2 + it > 255) ? 255 : 32'(2 + it));
    end

    // Reset mid-run with 0xA5 on the bus
    gray_in = 8'hA5;
    reset   = 1'b0;
    #1;
    chk_zero("rst_a5");
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rst_a5.e1.valid", 32'(bin_valid), 0);
    tick();
    chk("rst_a5.e2.valid", 32'(bin_valid), 1);
    chk("rst_a5.e2.bin", 32'(bin_out), 32'h0C6);
    chk("rst_a5.e2.err", 32'(err_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
